// File: rtl/asi_pkg.sv
// Shared types for the async-FIFO read-side write-beat engine.
// beat_t matches the default data width; the RTL itself stays width-parameterised.
package asi_pkg;
  localparam int ASI_DW = 128;
  localparam int ASI_LW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic              last;
    logic [ASI_DW-1:0] data;
  } beat_t;
endpackage

// File: rtl/asi_wbeat_if.sv
// Command, FIFO read port and write-data stream of asi_wbeat.
// The slave side is the beat engine; the master side drives commands, FIFO state and wready.
interface asi_wbeat_if #(parameter int DW = 128, parameter int LW = 8);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          fifo_rempty;
  logic          fifo_re;
  logic [DW-1:0] fifo_q;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          wlast;

  modport slave (
    input  cmd_valid, cmd_len, fifo_rempty, fifo_q, wready,
    output cmd_ready, fifo_re, wvalid, wdata, wlast
  );

  modport master (
    output cmd_valid, cmd_len, fifo_rempty, fifo_q, wready,
    input  cmd_ready, fifo_re, wvalid, wdata, wlast
  );
endinterface

// File: rtl/asi_skid2.sv
// Two-entry registered valid/ready buffer; head register drives the outputs directly.
// A push while full is only taken if the head leaves in the same cycle.
module asi_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         full
);
  logic [1:0]   cnt;
  logic [W-1:0] head, tail;
  logic         take, put;

  assign valid = (cnt != 2'd0);
  assign full  = (cnt == 2'd2);
  assign dout  = head;
  assign take  = valid & ready;
  assign put   = push & (~full | take);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      cnt <= cnt + 2'(put) - 2'(take);
      if (take) begin
        // head leaves: promote tail if present, else refill straight from din
        if (cnt == 2'd2) begin
          head <= tail;
          if (put) tail <= din;
        end else if (put) begin
          head <= din;
        end
      end else if (put) begin
        if (cnt == 2'd0) head <= din;
        else             tail <= din;
      end
    end
  end
endmodule

// File: rtl/asi_wbeat.sv
// Read-side burst engine: pops cmd_len+1 words from a fall-through FIFO and
// emits them as a registered valid/ready stream with wlast on each burst's final beat.
module asi_wbeat
  import asi_pkg::*;
#(
  parameter int DW = ASI_DW,
  parameter int LW = ASI_LW
) (
  input  logic        clk,
  input  logic        reset_n,
  asi_wbeat_if.slave  bus,
  output logic        busy
);
  state_e        state, state_nxt;
  logic [LW-1:0] rem;
  logic          pop, buf_full, buf_vld;
  logic [DW:0]   din, head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.cmd_valid && bus.cmd_ready) rem <= bus.cmd_len;
      else if (pop && rem != '0)          rem <= rem - LW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid)       state_nxt = BURST;
      BURST:   if (pop && rem == '0)    state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // FIFO read is fall-through, so fifo_q is captured in the same cycle as the pop
  always_comb begin
    bus.cmd_ready = (state == IDLE);
    pop           = (state == BURST) & ~bus.fifo_rempty & ~buf_full;
    bus.fifo_re   = pop;
    busy          = (state == BURST) | buf_vld;
  end

  assign din = {(rem == '0), bus.fifo_q};

  asi_skid2 #(.W(DW + 1)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (pop),
    .din     (din),
    .ready   (bus.wready),
    .valid   (buf_vld),
    .dout    (head),
    .full    (buf_full)
  );

  assign bus.wvalid = buf_vld;
  assign bus.wlast  = head[DW];
  assign bus.wdata  = head[DW-1:0];
endmodule
